// File: rtl/reg_file_if.sv
// Bundled read/write port signals of the register file.
// The master drives the addresses and write data; the slave returns the read data.
interface reg_file_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] write_reg;
    logic              reg_write_en;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] reg_data1;
    logic [DATA_W-1:0] reg_data2;

    modport master (
        output rs_addr, rt_addr, write_reg, reg_write_en, write_data,
        input  reg_data1, reg_data2
    );

    modport slave (
        input  rs_addr, rt_addr, write_reg, reg_write_en, write_data,
        output reg_data1, reg_data2
    );
endinterface

// File: rtl/reg_file.sv
// Two-read, one-write register file with a hard-wired zero register and synchronous reset.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto a matching read port.
module reg_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input logic       clk_i,
    input logic       rst_ni,
    reg_file_if.slave bus
);
    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NumRegs];
    logic [DATA_W-1:0] regs_d [NumRegs];
    logic              wr_valid;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    assign wr_valid = bus.reg_write_en && (bus.write_reg != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_valid) begin
            regs_d[bus.write_reg] = bus.write_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd1 = regs_q[bus.rs_addr];
        rd2 = regs_q[bus.rt_addr];
`ifdef REG_FILE_BYPASS_EN
        // A write lost to reset must not be forwarded either.
        if (rst_ni && wr_valid && (bus.write_reg == bus.rs_addr)) begin
            rd1 = bus.write_data;
        end
        if (rst_ni && wr_valid && (bus.write_reg == bus.rt_addr)) begin
            rd2 = bus.write_data;
        end
`endif
        if (bus.rs_addr == '0) begin
            rd1 = '0;
        end
        if (bus.rt_addr == '0) begin
            rd2 = '0;
        end
    end

    assign bus.reg_data1 = rd1;
    assign bus.reg_data2 = rd2;
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file; expected read values are hand-computed per vector.
// Pre-edge forwarding expectations follow the REG_FILE_BYPASS_EN build option.
module tb_reg_file;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        bus.write_reg    = addr;
        bus.write_data   = data;
        bus.reg_write_en = 1'b1;
        tick();
        bus.reg_write_en = 1'b0;
    endtask

    task automatic set_read(input logic [4:0] rs, input logic [4:0] rt);
        bus.rs_addr = rs;
        bus.rt_addr = rt;
        #1;
    endtask

    initial begin
        logic [31:0] pre_exp;
        checks           = 0;
        failures         = 0;
        rst_n            = 1'b0;
        bus.rs_addr      = '0;
        bus.rt_addr      = '0;
        bus.write_reg    = '0;
        bus.write_data   = '0;
        bus.reg_write_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        set_read(5'd5, 5'd31);
        check_eq("reset_r5", bus.reg_data1, 32'h0);
        check_eq("reset_r31", bus.reg_data2, 32'h0);

        // r5 write, visible after the edge
        set_read(5'd5, 5'd0);
        write_reg(5'd5, 32'hA5A5_A5A5);
        #1;
        check_eq("wr_r5_rd1", bus.reg_data1, 32'hA5A5_A5A5);
        check_eq("wr_r5_rd2_zero", bus.reg_data2, 32'h0);

        // Writes to r0 are discarded, even pre-edge
        set_read(5'd0, 5'd0);
        bus.write_reg    = 5'd0;
        bus.write_data   = 32'hFFFF_FFFF;
        bus.reg_write_en = 1'b1;
        #1;
        check_eq("r0_pre_edge", bus.reg_data1, 32'h0);
        tick();
        bus.reg_write_en = 1'b0;
        #1;
        check_eq("r0_post_rd1", bus.reg_data1, 32'h0);
        check_eq("r0_post_rd2", bus.reg_data2, 32'h0);

        // Disabled writes change nothing
        bus.write_reg  = 5'd7;
        bus.write_data = 32'h1234_5678;
        set_read(5'd5, 5'd7);
        tick();
        tick();
        tick();
        check_eq("we0_r7", bus.reg_data2, 32'h0);
        check_eq("we0_r5_hold", bus.reg_data1, 32'hA5A5_A5A5);

        write_reg(5'd3, 32'h0000_00C3);
        write_reg(5'd31, 32'hDEAD_BEEF);
        set_read(5'd31, 5'd3);
        check_eq("r31", bus.reg_data1, 32'hDEAD_BEEF);
        check_eq("r3", bus.reg_data2, 32'h0000_00C3);
        set_read(5'd3, 5'd3);
        check_eq("same_addr_rd1", bus.reg_data1, 32'h0000_00C3);
        check_eq("same_addr_rd2", bus.reg_data2, 32'h0000_00C3);

        // Reset is synchronous: nothing clears before the edge
        set_read(5'd31, 5'd3);
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_r31", bus.reg_data1, 32'hDEAD_BEEF);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("rst_r31", bus.reg_data1, 32'h0);
        check_eq("rst_r3", bus.reg_data2, 32'h0);
        set_read(5'd5, 5'd5);
        check_eq("rst_r5", bus.reg_data1, 32'h0);

        // Reset beats a simultaneous write, and it is not forwarded
        set_read(5'd9, 5'd9);
        rst_n            = 1'b0;
        bus.write_reg    = 5'd9;
        bus.write_data   = 32'h1;
        bus.reg_write_en = 1'b1;
        #1;
        check_eq("rst_wr_pre", bus.reg_data1, 32'h0);
        tick();
        rst_n            = 1'b1;
        bus.reg_write_en = 1'b0;
        #1;
        check_eq("rst_wr_r9", bus.reg_data1, 32'h0);

        // Same-cycle read of the register being written
        set_read(5'd4, 5'd4);
        bus.write_reg    = 5'd4;
        bus.write_data   = 32'h55AA_55AA;
        bus.reg_write_en = 1'b1;
        #1;
`ifdef REG_FILE_BYPASS_EN
        pre_exp = 32'h55AA_55AA;
`else
        pre_exp = 32'h0;
`endif
        check_eq("r4_pre_rd1", bus.reg_data1, pre_exp);
        check_eq("r4_pre_rd2", bus.reg_data2, pre_exp);
        tick();
        bus.reg_write_en = 1'b0;
        #1;
        check_eq("r4_post_rd1", bus.reg_data1, 32'h55AA_55AA);
        check_eq("r4_post_rd2", bus.reg_data2, 32'h55AA_55AA);

        // Only the addressed register is written
        write_reg(5'd1, 32'h1111_1111);
        write_reg(5'd2, 32'h2222_2222);
        set_read(5'd1, 5'd2);
        check_eq("r1_hold", bus.reg_data1, 32'h1111_1111);
        check_eq("r2", bus.reg_data2, 32'h2222_2222);
        set_read(5'd4, 5'd0);
        check_eq("r4_hold", bus.reg_data1, 32'h55AA_55AA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter DATA_W, default 32, SHALL set the register and data width in bits.
REQ-003 Parameter ADDR_W, default 5, SHALL set the address width; register count is 2**ADDR_W (32).
REQ-004 Clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-005 Rst_n  input  1  SHALL be the synchronous active-low reset.
REQ-006 RsAddr  input  ADDR_W  SHALL be the read port 1 address.
REQ-007 RtAddr  input  ADDR_W  SHALL be the read port 2 address.
REQ-008 WriteReg  input  ADDR_W  SHALL be the write port address.
REQ-009 RegWriteEn  input  1  SHALL be the write enable, active high.
REQ-010 WriteData  input  DATA_W  SHALL be the write data.
REQ-011 RegData1  output  DATA_W  SHALL be the read data for RsAddr.
REQ-012 RegData2  output  DATA_W  SHALL be the read data for RtAddr.

Function
REQ-013 Storage SHALL be 2**ADDR_W registers of DATA_W bits.
REQ-014 Reads SHALL be combinational, with zero-cycle latency: RegData1 = reg[RsAddr] and RegData2 = reg[RtAddr].
REQ-015 On a rising Clk with Rst_n=1, RegWriteEn=1 and WriteReg!=0, reg[WriteReg] SHALL take WriteData.
REQ-016 With RegWriteEn=0, no register SHALL change.
REQ-017 Register 0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-018 Both read ports SHALL be independent; RsAddr==RtAddr SHALL return identical data on both ports.
REQ-019 A written value SHALL be visible on the read ports from the cycle after the write edge; there is no bypass unless REQ-025 applies.
REQ-020 Only one register SHALL be written per cycle; all other registers SHALL hold their values.
REQ-021 The outputs SHALL never be X or Z after the first reset.

Reset
REQ-022 While Rst_n=0 at a rising Clk, all registers SHALL clear to 0, so RegData1 and RegData2 read 0 for any address.
REQ-023 Reset SHALL take priority over a simultaneous write; the write SHALL be lost.
REQ-024 Reset SHALL have no effect between clock edges, because it is synchronous.

Configuration
REQ-025 With macro REG_FILE_BYPASS_EN defined:
- when RegWriteEn=1, Rst_n=1 and WriteReg!=0 equals a read address, that read port SHALL output WriteData combinationally in the same cycle.
- address 0 SHALL still read 0.
Without the macro, read ports SHALL show stored contents only, per REQ-019.

Verification
REQ-026 Reset, then write r5=32'hA5A5A5A5 with RegWriteEn pulsed for one edge, RsAddr=5, RtAddr=0 -> after the edge RegData1=32'hA5A5A5A5 and RegData2=0.
REQ-027 Set WriteReg=0, WriteData=32'hFFFFFFFF, RegWriteEn=1 for one edge, RsAddr=0 -> RegData1=0.
REQ-028 Set RegWriteEn=0, WriteReg=7, WriteData=32'h12345678 for several edges -> RtAddr=7 reads its prior value of 0.
REQ-029 Write r3=32'h0000_00C3 and r31=32'hDEAD_BEEF, then read RsAddr=31, RtAddr=3 -> 32'hDEADBEEF and 32'h000000C3; then hold Rst_n=0 for one edge -> both read 0.
REQ-030 Set Rst_n=0 and RegWriteEn=1, WriteReg=9, WriteData=32'h1 on the same edge -> r9 reads 0.
REQ-031 Set WriteReg=RsAddr=4, WriteData=32'h55AA55AA, RegWriteEn=1 before the edge -> RegData1=32'h55AA55AA pre-edge with REG_FILE_BYPASS_EN, and the old value (0) pre-edge without it; 32'h55AA55AA post-edge in both builds.
